// File: rtl/ppg_dg412_drive_mc.sv
// ppg_dg412_drive_mc: multi-channel complementary DG412 switch driver.
// Each channel turns cki[i] into the non-overlapping pair ckop[i]/ckon[i].
// It inserts an independent rising deadtime (tdt_r) and falling deadtime (tdt_f).
// An input glitch inside a deadtime aborts back to the previously driven output.
// A sticky fault kills all outputs until arm is dropped and raised again.
module ppg_dg412_drive_mc #(
    parameter int NCH   = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk_fast,
    input  logic             rstn,
    input  logic             arm,
    input  logic             fault,
    input  logic [NCH-1:0]   cki,
    input  logic [WIDTH-1:0] tdt_r,
    input  logic [WIDTH-1:0] tdt_f,
    output logic [NCH-1:0]   ckop,
    output logic [NCH-1:0]   ckon,
    output logic             armed,
    output logic             faulted
);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_DTR  = 2'd1,
        S_HIGH = 2'd2,
        S_DTF  = 2'd3
    } state_t;

    logic arm_r;
    logic fault_r;
    logic en;

    assign en      = arm_r & ~fault_r;
    assign armed   = en;
    assign faulted = fault_r;

    // Register arm; latch fault while armed, clear it only once arm_r has dropped.
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            arm_r   <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            arm_r <= arm;
            if (fault && arm_r) begin
                fault_r <= 1'b1;
            end else if (!arm_r) begin
                fault_r <= 1'b0;
            end
        end
    end

    genvar g;
    for (g = 0; g < NCH; g++) begin : g_ch
        state_t           st;
        logic [WIDTH-1:0] cnt;

        // Per-channel deadtime FSM; deadtimes are captured only on entry to a deadtime state.
        always_ff @(posedge clk_fast or negedge rstn) begin
            if (!rstn) begin
                st  <= S_LOW;
                cnt <= '0;
            end else if (!en) begin
                st  <= S_LOW;
                cnt <= '0;
            end else begin
                case (st)
                    S_LOW: begin
                        if (cki[g]) begin
                            if (tdt_r == '0) begin
                                st <= S_HIGH;
                            end else begin
                                st  <= S_DTR;
                                cnt <= tdt_r;
                            end
                        end
                    end
                    S_DTR: begin
                        if (!cki[g]) begin
                            // Glitch: return to the side that was last driven.
                            st  <= S_LOW;
                            cnt <= '0;
                        end else begin
                            if (cnt == WIDTH'(1)) begin
                                st <= S_HIGH;
                            end
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (!cki[g]) begin
                            if (tdt_f == '0) begin
                                st <= S_LOW;
                            end else begin
                                st  <= S_DTF;
                                cnt <= tdt_f;
                            end
                        end
                    end
                    S_DTF: begin
                        if (cki[g]) begin
                            st  <= S_HIGH;
                            cnt <= '0;
                        end else begin
                            if (cnt == WIDTH'(1)) begin
                                st <= S_LOW;
                            end
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        st  <= S_LOW;
                        cnt <= '0;
                    end
                endcase
            end
        end

        // Drives decode straight from state, so both are low during any deadtime.
        assign ckop[g] = (st == S_HIGH) & en;
        assign ckon[g] = (st == S_LOW) & en;
    end

endmodule

// File: tb/tb_ppg_dg412_drive_mc.sv
// Testbench for ppg_dg412_drive_mc: vector table, directed corner sequences,
// and randomized traffic against a level/deadtime reference model.
module tb_ppg_dg412_drive_mc;

    localparam int NCH   = 4;
    localparam int WIDTH = 4;

    logic             clk_fast = 1'b0;
    logic             rstn;
    logic             arm;
    logic             fault;
    logic [NCH-1:0]   cki;
    logic [WIDTH-1:0] tdt_r;
    logic [WIDTH-1:0] tdt_f;
    logic [NCH-1:0]   ckop;
    logic [NCH-1:0]   ckon;
    logic             armed;
    logic             faulted;

    int n_vec = 0;
    int n_err = 0;

    ppg_dg412_drive_mc #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk_fast (clk_fast),
        .rstn     (rstn),
        .arm      (arm),
        .fault    (fault),
        .cki      (cki),
        .tdt_r    (tdt_r),
        .tdt_f    (tdt_f),
        .ckop     (ckop),
        .ckon     (ckon),
        .armed    (armed),
        .faulted  (faulted)
    );

    always #5 clk_fast = ~clk_fast;

    typedef struct {
        logic       arm;
        logic       fault;
        logic [3:0] cki;
        logic [3:0] tr;
        logic [3:0] tf;
        logic [3:0] op;
        logic [3:0] on;
        logic       armed;
        logic       flt;
    } vec_t;

    vec_t tbl [16];

    // Reference model: per channel, the settled drive level and remaining dead cycles.
    bit arm_m;
    bit flt_m;
    int lvl  [NCH];
    int dead [NCH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_fast);
        #1;
    endtask

    function automatic vec_t mk(input logic a, input logic f, input logic [3:0] c,
                                input logic [3:0] tr, input logic [3:0] tf,
                                input logic [3:0] op, input logic [3:0] on,
                                input logic ar, input logic fl);
        vec_t v;
        v.arm = a; v.fault = f; v.cki = c; v.tr = tr; v.tf = tf;
        v.op = op; v.on = on; v.armed = ar; v.flt = fl;
        return v;
    endfunction

    task automatic model_reset();
        arm_m = 0;
        flt_m = 0;
        for (int i = 0; i < NCH; i++) begin
            lvl[i]  = 0;
            dead[i] = 0;
        end
    endtask

    task automatic model_step();
        bit en_old;
        int want;
        en_old = arm_m && !flt_m;
        if (fault && arm_m) flt_m = 1;
        else if (!arm_m)    flt_m = 0;
        arm_m = arm;
        for (int i = 0; i < NCH; i++) begin
            want = int'(cki[i]);
            if (!en_old) begin
                lvl[i]  = 0;
                dead[i] = 0;
            end else if (dead[i] == 0) begin
                if (want != lvl[i]) begin
                    dead[i] = (want == 1) ? int'(tdt_r) : int'(tdt_f);
                    if (dead[i] == 0) lvl[i] = want;
                end
            end else if (want == lvl[i]) begin
                dead[i] = 0;
            end else begin
                dead[i]--;
                if (dead[i] == 0) lvl[i] = want;
            end
        end
    endtask

    task automatic model_compare(input string name);
        logic [3:0] eop, eon;
        bit en;
        en = arm_m && !flt_m;
        for (int i = 0; i < NCH; i++) begin
            eop[i] = en && dead[i] == 0 && lvl[i] == 1;
            eon[i] = en && dead[i] == 0 && lvl[i] == 0;
        end
        chk(name, {22'd0, ckop, ckon, armed, faulted}, {22'd0, eop, eon, en, flt_m});
        chk("overlap", {28'd0, ckop & ckon}, 32'd0);
    endtask

    initial begin
        rstn = 0; arm = 0; fault = 0; cki = '0; tdt_r = '0; tdt_f = '0;

        //            arm f  cki      tr tf  op       on       armed flt
        tbl[0]  = mk(0, 0, 4'b0000, 0, 0, 4'h0, 4'h0, 0, 0);
        tbl[1]  = mk(1, 0, 4'b0000, 0, 0, 4'h0, 4'h0, 0, 0);
        tbl[2]  = mk(1, 0, 4'b0001, 0, 0, 4'h0, 4'hF, 1, 0);
        tbl[3]  = mk(1, 0, 4'b0010, 0, 0, 4'h1, 4'hE, 1, 0);
        tbl[4]  = mk(1, 0, 4'b0110, 0, 0, 4'h2, 4'hD, 1, 0);
        tbl[5]  = mk(1, 0, 4'b1111, 2, 0, 4'h6, 4'h9, 1, 0);
        tbl[6]  = mk(1, 0, 4'b1111, 2, 0, 4'h6, 4'h0, 1, 0);
        tbl[7]  = mk(1, 0, 4'b1111, 2, 0, 4'h6, 4'h0, 1, 0);
        tbl[8]  = mk(1, 1, 4'b1111, 0, 0, 4'hF, 4'h0, 1, 0);
        tbl[9]  = mk(1, 0, 4'b1111, 0, 0, 4'h0, 4'h0, 0, 1);
        tbl[10] = mk(0, 0, 4'b0000, 0, 0, 4'h0, 4'h0, 0, 1);
        tbl[11] = mk(0, 0, 4'b0000, 0, 0, 4'h0, 4'h0, 0, 1);
        tbl[12] = mk(1, 0, 4'b0000, 0, 0, 4'h0, 4'h0, 0, 0);
        tbl[13] = mk(0, 1, 4'b0000, 0, 0, 4'h0, 4'hF, 1, 0);
        tbl[14] = mk(0, 0, 4'b0000, 0, 0, 4'h0, 4'h0, 0, 1);
        tbl[15] = mk(0, 1, 4'b0000, 0, 0, 4'h0, 4'h0, 0, 0);

        // Reset state
        #12;
        chk("reset", {22'd0, ckop, ckon, armed, faulted}, 32'd0);
        @(negedge clk_fast);
        rstn = 1;
        #1;

        // Table: each row's expected outputs are the state before its inputs are clocked;
        // they are checked after the following edge, so the pairing is shifted by one row.
        for (int r = 0; r < 16; r++) begin
            arm = tbl[r].arm; fault = tbl[r].fault; cki = tbl[r].cki;
            tdt_r = tbl[r].tr; tdt_f = tbl[r].tf;
            step();
            if (r < 15)
                chk($sformatf("tbl%0d", r),
                    {22'd0, ckop, ckon, armed, faulted},
                    {22'd0, tbl[r+1].op, tbl[r+1].on, tbl[r+1].armed, tbl[r+1].flt});
        end
        chk("tbl15", {22'd0, ckop, ckon, armed, faulted}, {22'd0, 4'h0, 4'h0, 1'b0, 1'b0});

        // T2: zero deadtime, cki[1] toggles every cycle
        fault = 0; arm = 1; cki = '0; tdt_r = 0; tdt_f = 0;
        step(); step();
        for (int c = 0; c < 8; c++) begin
            cki[1] = ~cki[1];
            step();
            chk("t2_mirror", {30'd0, ckop[1], ckon[1]}, {30'd0, cki[1], ~cki[1]});
        end
        cki = '0; step(); step();

        // T1: tdt_r=3, tdt_f=2 on channel 0
        tdt_r = 3; tdt_f = 2;
        cki[0] = 1;
        step();
        chk("t1_rise_k", {30'd0, ckop[0], ckon[0]}, 32'd0);
        step(); step();
        chk("t1_rise_k2", {30'd0, ckop[0], ckon[0]}, 32'd0);
        step();
        chk("t1_rise_k3", {30'd0, ckop[0], ckon[0]}, 32'b10);
        for (int c = 0; c < 6; c++) step();
        chk("t1_hold", {30'd0, ckop[0], ckon[0]}, 32'b10);
        cki[0] = 0;
        step();
        chk("t1_fall_k", {30'd0, ckop[0], ckon[0]}, 32'd0);
        step();
        chk("t1_fall_k1", {30'd0, ckop[0], ckon[0]}, 32'd0);
        step();
        chk("t1_fall_k2", {30'd0, ckop[0], ckon[0]}, 32'b01);

        // T3: DT_R abort on channel 2
        tdt_r = 5;
        cki[2] = 1;
        step();
        chk("t3_k", {30'd0, ckop[2], ckon[2]}, 32'd0);
        step();
        chk("t3_k1", {30'd0, ckop[2], ckon[2]}, 32'd0);
        cki[2] = 0;
        step();
        chk("t3_k2", {30'd0, ckop[2], ckon[2]}, 32'b01);
        for (int c = 0; c < 6; c++) step();
        chk("t3_after", {30'd0, ckop[2], ckon[2]}, 32'b01);

        // T5: tdt_r changed mid-count does not affect the running count
        tdt_r = 7;
        cki[3] = 1;
        step();
        chk("t5_entry", {30'd0, ckop[3], ckon[3]}, 32'd0);
        step(); step();
        tdt_r = 1;
        for (int j = 3; j < 7; j++) step();
        chk("t5_j6", {30'd0, ckop[3], ckon[3]}, 32'd0);
        step();
        chk("t5_j7", {30'd0, ckop[3], ckon[3]}, 32'b10);

        // T4: fault pulse with all channels running
        tdt_r = 0; tdt_f = 0; cki = 4'b0101;
        step(); step();
        chk("t4_run", {22'd0, ckop, ckon, armed, faulted}, {22'd0, 4'h5, 4'hA, 1'b1, 1'b0});
        fault = 1;
        step();
        chk("t4_kill", {22'd0, ckop, ckon, armed, faulted}, {22'd0, 4'h0, 4'h0, 1'b0, 1'b1});
        fault = 0;
        step(); step();
        chk("t4_sticky", {22'd0, ckop, ckon, armed, faulted}, {22'd0, 4'h0, 4'h0, 1'b0, 1'b1});
        arm = 0;
        step(); step();
        chk("t4_clear", {22'd0, ckop, ckon, armed, faulted}, 32'd0);
        arm = 1;
        step();
        chk("t4_rearm", {22'd0, ckop, ckon, armed, faulted}, {22'd0, 4'h0, 4'hF, 1'b1, 1'b0});
        step();
        chk("t4_resume", {22'd0, ckop, ckon, armed, faulted}, {22'd0, 4'h5, 4'hA, 1'b1, 1'b0});

        // T6: asynchronous reset during a long DT_F
        cki = 4'b0010; tdt_f = 15;
        step();
        cki = 4'b0000;
        step();
        chk("t6_dtf", {30'd0, ckop[1], ckon[1]}, 32'd0);
        step(); step();
        #2;
        rstn = 0;
        #1;
        chk("t6_async", {22'd0, ckop, ckon, armed, faulted}, 32'd0);
        @(negedge clk_fast);
        rstn = 1;
        step();
        chk("t6_rearm", {22'd0, ckop, ckon, armed, faulted}, {22'd0, 4'h0, 4'hF, 1'b1, 1'b0});

        // Randomized traffic against the reference model
        arm = 0; fault = 0; cki = '0;
        @(negedge clk_fast);
        rstn = 0;
        model_reset();
        @(negedge clk_fast);
        rstn = 1;
        #1;
        for (int c = 0; c < 3000; c++) begin
            arm   = ($urandom_range(0, 39) != 0);
            fault = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 3) == 0) cki[i] = ~cki[i];
            if ($urandom_range(0, 7) == 0) tdt_r = WIDTH'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) tdt_f = WIDTH'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) tdt_r = 4'hF;
            @(posedge clk_fast);
            model_step();
            #1;
            model_compare("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
